// File: rtl/lvl1_scan_ctrl_pkg.sv
// lvl1_scan_pkg: op codes, FSM states and default widths for the lvl1 scan sequencer
package lvl1_scan_pkg;
  localparam int DEF_STATE_W = 16;
  localparam int DEF_LEN_W = 16;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_RUN = 2'b01, OP_CAPTURE = 2'b10, OP_INJECT = 2'b11} op_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SHIFT, S_RESP} state_t;
endpackage

// File: rtl/lvl1_scan_ctrl_if.sv
// lvl1_scan_ctrl_if: host command and response channels of the lvl1 scan sequencer
interface lvl1_scan_ctrl_if
  import lvl1_scan_pkg::*;
#(
  parameter int STATE_W = DEF_STATE_W,
  parameter int LEN_W = DEF_LEN_W
);
  logic cmd_valid;
  logic cmd_ready;
  op_t cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic [STATE_W-1:0] cmd_data;
  logic rsp_valid;
  logic rsp_ready;
  logic [STATE_W-1:0] rsp_data;
  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input cmd_ready, rsp_valid, rsp_data
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/lvl1_scan_ctrl_step_cnt.sv
// lvl1_step_cnt: loadable down-counter with zero flag, shared by RUN and SHIFT phases
module lvl1_step_cnt #(
  parameter int W = 16
) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic [W-1:0] load_val,
  input logic dec,
  output logic zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/lvl1_scan_ctrl.sv
// lvl1_scan_ctrl: runs, captures or injects the lvl1 datapath state on host command
module lvl1_scan_ctrl
  import lvl1_scan_pkg::*;
#(
  parameter int STATE_W = DEF_STATE_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input logic clk,
  input logic rst,
  lvl1_scan_ctrl_if.slave bus,
  output logic dp_en,
  output logic dp_scan_en,
  output logic dp_scan_in,
  input logic dp_scan_out,
  output logic busy
);
  state_t state, state_n;
  op_t op;
  logic [STATE_W-1:0] sh, cap;
  logic accept, dec, zero;
  logic [LEN_W-1:0] load_val;
  assign accept = state == S_IDLE && bus.cmd_valid;
  // counter is preloaded with count-1 so the enable spans exactly the requested cycles
  assign load_val = bus.cmd_op == OP_RUN ? bus.cmd_len - 1'b1 : LEN_W'(STATE_W - 1);
  assign dec = (state == S_RUN || state == S_SHIFT) && !zero;
  lvl1_step_cnt #(.W(LEN_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .load_val(load_val),
    .dec(dec),
    .zero(zero)
  );
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (bus.cmd_valid) state_n = bus.cmd_op == OP_RUN && bus.cmd_len != '0 ? S_RUN :
                                          bus.cmd_op inside {OP_CAPTURE, OP_INJECT} ? S_SHIFT : S_RESP;
      S_RUN, S_SHIFT: if (zero) state_n = S_RESP;
      S_RESP: if (bus.rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      op <= OP_NOP;
      sh <= '0;
      cap <= '0;
      dp_en <= 1'b0;
      dp_scan_en <= 1'b0;
    end else begin
      state <= state_n;
      dp_en <= state_n == S_RUN;
      dp_scan_en <= state_n == S_SHIFT;
      if (accept) begin
        op <= bus.cmd_op;
        sh <= bus.cmd_data;
        cap <= '0;
      end else if (dp_scan_en) begin
        sh <= {sh[STATE_W-2:0], 1'b0};
        cap <= {cap[STATE_W-2:0], dp_scan_out};
      end
    end
  end
  // capture rotates the chain so the datapath ends unchanged
  assign dp_scan_in = op == OP_CAPTURE ? dp_scan_out : sh[STATE_W-1];
  assign bus.cmd_ready = state == S_IDLE;
  assign bus.rsp_valid = state == S_RESP;
  assign bus.rsp_data = bus.rsp_valid ? cap : '0;
  assign busy = state != S_IDLE;
endmodule

// File: tb/tb_lvl1_scan_ctrl.sv
// tb_lvl1_scan_ctrl: directed commands against a lvl1 datapath model with a response scoreboard
module tb_lvl1_scan_ctrl;
  import lvl1_scan_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dp_rst = 1'b0;
  always #5 clk = ~clk;
  lvl1_scan_ctrl_if bus ();
  logic dp_en, dp_scan_en, dp_scan_in, dp_scan_out, busy;
  lvl1_scan_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dp_en(dp_en),
    .dp_scan_en(dp_scan_en),
    .dp_scan_in(dp_scan_in),
    .dp_scan_out(dp_scan_out),
    .busy(busy)
  );
  logic [7:0] one, two;
  always @(posedge clk) begin
    if (!dp_rst) begin
      one <= 8'hDE;
      two <= 8'hBE;
    end else if (dp_en) begin
      one <= one + 8'h09;
      two <= two + 8'h0B;
    end else if (dp_scan_en) {one, two} <= {one[6:0], two, dp_scan_in};
  end
  assign dp_scan_out = one[7];
  int n_vec = 0;
  int n_err = 0;
  int en_cnt = 0;
  int sc_cnt = 0;
  logic [15:0] exp_q[$];
  always @(posedge clk) begin
    if (dp_en) en_cnt <= en_cnt + 1;
    if (dp_scan_en) sc_cnt <= sc_cnt + 1;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (dp_en || dp_scan_en) chk("en_exclusive", {31'd0, dp_en && dp_scan_en}, 32'd0);
    if (bus.rsp_valid && bus.rsp_ready) begin
      chk("rsp_expected", exp_q.size(), 32'd1);
      if (exp_q.size() > 0) chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, exp_q.pop_front()});
    end
  end
  task automatic issue(input op_t op, input logic [15:0] len, input logic [15:0] data);
    @(negedge clk);
    chk("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_len = len;
    bus.cmd_data = data;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_idle();
    logic ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.cmd_ready && !bus.rsp_valid;
    end
    chk("idle_timeout", {31'd0, ok}, 32'd1);
  endtask
  task automatic run_cmd(input string name, input op_t op, input logic [15:0] len, input logic [15:0] data,
                         input logic [15:0] exp, input int exp_en, input int exp_sc);
    int e, s;
    e = en_cnt;
    s = sc_cnt;
    exp_q.push_back(exp);
    issue(op, len, data);
    if (exp_en > 0) chk({name, "_first_en"}, {31'd0, dp_en}, 32'd1);
    if (exp_sc > 0) chk({name, "_first_scan"}, {31'd0, dp_scan_en}, 32'd1);
    if (exp_en == 0 && exp_sc == 0) chk({name, "_rsp_t1"}, {31'd0, bus.rsp_valid}, 32'd1);
    wait_idle();
    chk({name, "_en_cycles"}, en_cnt - e, exp_en);
    chk({name, "_scan_cycles"}, sc_cnt - s, exp_sc);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int e, s;
    logic ok;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = OP_NOP;
    bus.cmd_len = '0;
    bus.cmd_data = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    chk("rst_dp_en", {31'd0, dp_en}, 32'd0);
    chk("rst_dp_scan_en", {31'd0, dp_scan_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    dp_rst = 1'b1;
    run_cmd("t1_cap", OP_CAPTURE, 16'd0, 16'd0, 16'hDEBE, 0, 16);
    run_cmd("t1_cap2", OP_CAPTURE, 16'd0, 16'd0, 16'hDEBE, 0, 16);
    run_cmd("t2_run3", OP_RUN, 16'd3, 16'd0, 16'h0000, 3, 0);
    run_cmd("t2_cap", OP_CAPTURE, 16'd0, 16'd0, 16'hF9DF, 0, 16);
    run_cmd("t3_inj", OP_INJECT, 16'd0, 16'h1234, 16'hF9DF, 0, 16);
    run_cmd("t3_cap", OP_CAPTURE, 16'd0, 16'd0, 16'h1234, 0, 16);
    run_cmd("t4_run0", OP_RUN, 16'd0, 16'd0, 16'h0000, 0, 0);
    run_cmd("t4_nop", OP_NOP, 16'd7, 16'hFFFF, 16'h0000, 0, 0);
    bus.rsp_ready = 1'b0;
    e = en_cnt;
    exp_q.push_back(16'h1234);
    issue(OP_CAPTURE, 16'd0, 16'd0);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus.rsp_valid;
    end
    chk("t5_rsp_timeout", {31'd0, ok}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = OP_RUN;
    bus.cmd_len = 16'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("t5_rsp_data", {16'd0, bus.rsp_data}, 32'h1234);
      chk("t5_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      chk("t5_dp_en", {31'd0, dp_en}, 32'd0);
    end
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    wait_idle();
    chk("t5_no_run", en_cnt - e, 32'd0);
    s = sc_cnt;
    issue(OP_INJECT, 16'd0, 16'hABCD);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_dp_scan_en", {31'd0, dp_scan_en}, 32'd0);
    chk("t6_dp_en", {31'd0, dp_en}, 32'd0);
    chk("t6_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("t6_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    chk("t6_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_scan_cycles", sc_cnt - s, 32'd7);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_rsp_dropped", {31'd0, bus.rsp_valid}, 32'd0);
    chk("end_queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
